// File: rtl/wb_shared_bus.sv
// rtl/wb_shared_bus.sv - Shared-bus Wishbone interconnect, round-robin arbiter and address decode
module wb_shared_bus #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 4,
    parameter int SEL_HI      = 31,
    parameter int SEL_LO      = 28,
    parameter int TIMEOUT     = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_MASTERS-1:0]    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]    m_stb_i,
    input  logic [NUM_MASTERS-1:0]    m_we_i,
    input  logic [32*NUM_MASTERS-1:0] m_addr_i,
    input  logic [32*NUM_MASTERS-1:0] m_data_i,
    input  logic [4*NUM_MASTERS-1:0]  m_sel_i,
    output logic [32*NUM_MASTERS-1:0] m_data_o,
    output logic [NUM_MASTERS-1:0]    m_ack_o,
    output logic [NUM_MASTERS-1:0]    m_err_o,
    output logic [31:0]               s_addr_o,
    output logic [31:0]               s_data_o,
    output logic [3:0]                s_sel_o,
    output logic                      s_we_o,
    output logic [NUM_SLAVES-1:0]     s_cyc_o,
    output logic [NUM_SLAVES-1:0]     s_stb_o,
    input  logic [32*NUM_SLAVES-1:0]  s_data_i,
    input  logic [NUM_SLAVES-1:0]     s_ack_i,
    input  logic [NUM_SLAVES-1:0]     s_err_i,
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      busy_o
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = SEL_HI - SEL_LO + 1;

    typedef enum logic {ST_IDLE, ST_OWNED} state_t;

    state_t                 r_state;
    logic [NUM_MASTERS-1:0] r_grant;
    logic                   r_busy;
    logic [MW-1:0]          r_last_grant;
    logic [15:0]            r_stall;

    logic                   w_own_cyc, w_own_stb, w_own_we;
    logic [31:0]            w_own_addr, w_own_data;
    logic [3:0]             w_own_sel;
    logic                   w_owned, w_miss, w_timeout, w_sel_ok;
    logic [SW-1:0]          w_idx;
    logic                   w_hit_ack, w_hit_err;
    logic [31:0]            w_hit_data;
    logic                   w_rsp_ack, w_rsp_err, w_rsp_any;
    logic                   w_found;
    logic [MW-1:0]          w_cand, w_next;
    logic [NUM_MASTERS-1:0] w_next_grant;

    // The grant is one-hot, so OR-ing the masked master fields selects the owner.
    always_comb begin
        w_own_cyc  = 1'b0;
        w_own_stb  = 1'b0;
        w_own_we   = 1'b0;
        w_own_addr = '0;
        w_own_data = '0;
        w_own_sel  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (r_grant[k]) begin
                w_own_cyc  = w_own_cyc | m_cyc_i[k];
                w_own_stb  = w_own_stb | m_stb_i[k];
                w_own_we   = w_own_we  | m_we_i[k];
                w_own_addr = w_own_addr | m_addr_i[32*k +: 32];
                w_own_data = w_own_data | m_data_i[32*k +: 32];
                w_own_sel  = w_own_sel  | m_sel_i[4*k +: 4];
            end
        end
    end

    assign w_owned   = (r_state == ST_OWNED) && !rst;
    assign w_idx     = w_own_addr[SEL_HI:SEL_LO];
    assign w_miss    = 32'(w_idx) >= NUM_SLAVES;
    assign w_timeout = w_own_stb && (r_stall == 16'(TIMEOUT));
    assign w_sel_ok  = w_owned && !w_miss;

    always_comb begin
        w_hit_ack  = 1'b0;
        w_hit_err  = 1'b0;
        w_hit_data = '0;
        s_cyc_o    = '0;
        s_stb_o    = '0;
        for (int j = 0; j < NUM_SLAVES; j++) begin
            if (w_idx == SW'(j)) begin
                w_hit_ack  = s_ack_i[j];
                w_hit_err  = s_err_i[j];
                w_hit_data = s_data_i[32*j +: 32];
                s_cyc_o[j] = w_sel_ok && w_own_cyc;
                s_stb_o[j] = w_sel_ok && w_own_stb && !w_timeout;
            end
        end
    end

    assign w_rsp_ack = w_owned && w_own_stb && w_hit_ack;
    assign w_rsp_err = w_owned && w_own_stb && (w_hit_err || w_miss || w_timeout);
    assign w_rsp_any = w_hit_ack || w_hit_err || w_miss || w_timeout;

    always_comb begin
        m_ack_o  = '0;
        m_err_o  = '0;
        m_data_o = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            m_ack_o[k] = r_grant[k] && w_rsp_ack;
            m_err_o[k] = r_grant[k] && w_rsp_err;
            m_data_o[32*k +: 32] = (r_grant[k] && w_owned && w_own_stb) ? w_hit_data : 32'h0;
        end
    end

    assign s_addr_o = w_owned ? w_own_addr : 32'h0;
    assign s_data_o = w_owned ? w_own_data : 32'h0;
    assign s_sel_o  = w_owned ? w_own_sel  : 4'h0;
    assign s_we_o   = w_owned && w_own_we;

    // Round-robin scan starting just after the previous winner.
    always_comb begin
        w_found      = 1'b0;
        w_next       = r_last_grant;
        w_cand       = r_last_grant;
        w_next_grant = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_cand = (w_cand == MW'(NUM_MASTERS - 1)) ? '0 : w_cand + 1'b1;
            if (!w_found && m_cyc_i[w_cand]) begin
                w_found = 1'b1;
                w_next  = w_cand;
            end
        end
        for (int k = 0; k < NUM_MASTERS; k++) begin
            w_next_grant[k] = (w_next == MW'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_grant      <= '0;
            r_busy       <= 1'b0;
            r_stall      <= '0;
            r_last_grant <= MW'(NUM_MASTERS - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_stall <= '0;
                    if (w_found) begin
                        r_state      <= ST_OWNED;
                        r_grant      <= w_next_grant;
                        r_busy       <= 1'b1;
                        r_last_grant <= w_next;
                    end
                end
                ST_OWNED: begin
                    if (!w_own_cyc) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_busy  <= 1'b0;
                        r_stall <= '0;
                    end else if (!w_own_stb || w_rsp_any) begin
                        r_stall <= '0;
                    end else begin
                        r_stall <= r_stall + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign grant_o = r_grant;
    assign busy_o  = r_busy;
endmodule

// File: tb/tb_wb_shared_bus.sv
// tb/tb_wb_shared_bus.sv - Directed self-checking bench for wb_shared_bus
module tb_wb_shared_bus;
    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   m_cyc, m_stb, m_we;
    logic [63:0]  m_addr, m_wdata;
    logic [7:0]   m_sel;
    logic [63:0]  m_rdata;
    logic [1:0]   m_ack, m_err;
    logic [31:0]  s_addr, s_wdata;
    logic [3:0]   s_sel;
    logic         s_we;
    logic [3:0]   s_cyc, s_stb;
    logic [127:0] s_rdata;
    logic [3:0]   s_ack, s_err;
    logic [1:0]   grant;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    wb_shared_bus #(
        .NUM_MASTERS(2), .NUM_SLAVES(4), .SEL_HI(31), .SEL_LO(28), .TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we),
        .m_addr_i(m_addr), .m_data_i(m_wdata), .m_sel_i(m_sel),
        .m_data_o(m_rdata), .m_ack_o(m_ack), .m_err_o(m_err),
        .s_addr_o(s_addr), .s_data_o(s_wdata), .s_sel_o(s_sel), .s_we_o(s_we),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb),
        .s_data_i(s_rdata), .s_ack_i(s_ack), .s_err_i(s_err),
        .grant_o(grant), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst = 1'b1;
        m_cyc = '0; m_stb = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_sel = '0;
        s_rdata = '0; s_ack = '0; s_err = '0;

        // Reset held while a master is requesting
        m_cyc = 2'b01; m_stb = 2'b01;
        step(); step(); settle();
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_busy",  64'(busy),  64'h0);
        chk("rst_scyc",  64'(s_cyc), 64'h0);
        chk("rst_sstb",  64'(s_stb), 64'h0);
        chk("rst_mack",  64'(m_ack), 64'h0);
        chk("rst_merr",  64'(m_err), 64'h0);

        // Single read, zero-wait slave 1
        step(); rst = 1'b0; m_addr[31:0] = 32'h1000_0004; settle();
        chk("rd_idle_grant", 64'(grant), 64'h0);
        chk("rd_idle_sstb",  64'(s_stb), 64'h0);
        step(); s_ack = 4'b0010; s_rdata[63:32] = 32'hDEAD_BEEF; settle();
        chk("rd_grant", 64'(grant), 64'h1);
        chk("rd_busy",  64'(busy),  64'h1);
        chk("rd_sstb",  64'(s_stb), 64'h2);
        chk("rd_scyc",  64'(s_cyc), 64'h2);
        chk("rd_saddr", 64'(s_addr), 64'h1000_0004);
        chk("rd_mack",  64'(m_ack), 64'h1);
        chk("rd_data0", 64'(m_rdata[31:0]),  64'hDEAD_BEEF);
        chk("rd_data1", 64'(m_rdata[63:32]), 64'h0);
        step(); m_cyc = '0; m_stb = '0; s_ack = '0; settle();
        chk("rd_drop_sstb",  64'(s_stb), 64'h0);
        chk("rd_drop_grant", 64'(grant), 64'h1);
        step(); settle();
        chk("rd_idle_after", 64'(grant), 64'h0);
        chk("rd_busy_after", 64'(busy),  64'h0);

        // Simultaneous requests after reset: M0 first, dead cycle, M1, then M0 again
        rst = 1'b1; step(); rst = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11; m_addr = {32'h2000_0000, 32'h0000_0010}; settle();
        chk("rr_idle", 64'(grant), 64'h0);
        step(); s_ack = 4'b0001; settle();
        chk("rr_m0_grant", 64'(grant), 64'h1);
        chk("rr_m0_sstb",  64'(s_stb), 64'h1);
        chk("rr_m0_ack1",  64'(m_ack), 64'h1);
        step(); settle();
        chk("rr_m0_ack2",  64'(m_ack), 64'h1);
        step(); m_cyc = 2'b10; m_stb = 2'b10; s_ack = '0; settle();
        chk("rr_m0_hold",  64'(grant), 64'h1);
        chk("rr_m0_nostb", 64'(s_stb), 64'h0);
        step(); settle();
        chk("rr_dead_grant", 64'(grant), 64'h0);
        chk("rr_dead_busy",  64'(busy),  64'h0);
        step(); s_ack = 4'b0100; settle();
        chk("rr_m1_grant", 64'(grant), 64'h2);
        chk("rr_m1_sstb",  64'(s_stb), 64'h4);
        chk("rr_m1_ack1",  64'(m_ack), 64'h2);
        step(); settle();
        chk("rr_m1_ack2",  64'(m_ack), 64'h2);
        step(); m_cyc = '0; m_stb = '0; s_ack = '0;
        step(); m_cyc = 2'b11; m_stb = 2'b11; settle();
        chk("rr_idle2", 64'(grant), 64'h0);
        step(); settle();
        chk("rr_m0_again", 64'(grant), 64'h1);
        m_cyc = '0; m_stb = '0;
        step(); step(); settle();

        // Decode miss from M1
        m_cyc = 2'b10; m_stb = 2'b10; m_addr[63:32] = 32'h5000_0000;
        step(); settle();
        chk("miss_grant", 64'(grant), 64'h2);
        chk("miss_sstb",  64'(s_stb), 64'h0);
        chk("miss_scyc",  64'(s_cyc), 64'h0);
        chk("miss_err",   64'(m_err), 64'h2);
        m_stb = 2'b00; settle();
        chk("miss_err_nostb", 64'(m_err), 64'h0);
        m_cyc = '0;
        step(); step(); settle();

        // Timeout: slave 3 never answers
        m_addr[31:0] = 32'h3000_0000; m_cyc = 2'b01; m_stb = 2'b01;
        step(); settle();
        for (int n = 1; n <= 8; n++) begin
            chk("to_wait_err", 64'(m_err), 64'h0);
            chk("to_wait_stb", 64'(s_stb), 64'h8);
            step(); settle();
        end
        chk("to_err",   64'(m_err), 64'h1);
        chk("to_nostb", 64'(s_stb), 64'h0);
        step(); settle();
        chk("to_clr_err", 64'(m_err), 64'h0);
        chk("to_clr_stb", 64'(s_stb), 64'h8);
        m_cyc = '0; m_stb = '0;
        step(); settle();

        // M0 burst: M1 request must not preempt
        m_addr[31:0] = 32'h0; m_cyc = 2'b01; m_stb = 2'b01;
        step(); s_ack = 4'b0001; m_cyc = 2'b11; m_stb = 2'b11; m_addr[63:32] = 32'h2000_0000; settle();
        for (int n = 0; n < 5; n++) begin
            chk("burst_grant", 64'(grant), 64'h1);
            chk("burst_ack",   64'(m_ack), 64'h1);
            step(); settle();
        end
        m_cyc = 2'b10; m_stb = 2'b10; s_ack = '0; settle();
        chk("burst_end_grant", 64'(grant), 64'h1);
        step(); settle();
        chk("burst_dead", 64'(grant), 64'h0);
        step(); settle();
        chk("burst_m1", 64'(grant), 64'h2);
        m_cyc = '0; m_stb = '0;
        step(); settle();

        // Reset in the middle of a write
        m_we = 2'b01; m_wdata[31:0] = 32'h1234_5678; m_sel[3:0] = 4'hF;
        m_addr[31:0] = 32'h1000_0000; m_cyc = 2'b01; m_stb = 2'b01;
        step(); settle();
        chk("wr_grant", 64'(grant), 64'h1);
        chk("wr_swe",   64'(s_we),  64'h1);
        chk("wr_sdata", 64'(s_wdata), 64'h1234_5678);
        chk("wr_ssel",  64'(s_sel), 64'hF);
        chk("wr_sstb",  64'(s_stb), 64'h2);
        rst = 1'b1; s_ack = 4'b0010; settle();
        chk("wr_rst_ack",  64'(m_ack), 64'h0);
        chk("wr_rst_sstb", 64'(s_stb), 64'h0);
        step(); rst = 1'b0; s_ack = '0; settle();
        chk("wr_post_grant", 64'(grant), 64'h0);
        chk("wr_post_busy",  64'(busy),  64'h0);
        chk("wr_post_ack",   64'(m_ack), 64'h0);
        chk("wr_post_swe",   64'(s_we),  64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/wb_shared_bus.md
WB_SHARED_BUS -- requirements
Module: wb_shared_bus

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of Wishbone masters (1..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 4, number of Wishbone slaves (1..16).
REQ-003 SHALL have parameter SEL_HI, default 31, upper bit of the slave-select address field.
REQ-004 SHALL have parameter SEL_LO, default 28, lower bit of the slave-select address field; SEL_HI-SEL_LO+1 is at most 4.
REQ-005 SHALL have parameter TIMEOUT, default 255, stalled-cycle limit before a bus error (1..65535).
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have ports m_cyc_i, m_stb_i and m_we_i, each input, NUM_MASTERS, per-master Wishbone control.
REQ-009 SHALL have ports m_addr_i, input, 32*NUM_MASTERS, and m_data_i, input, 32*NUM_MASTERS, packed per master with master k at [32k+31:32k].
REQ-010 SHALL have port m_sel_i, input, 4*NUM_MASTERS, per-master byte selects.
REQ-011 SHALL have ports m_data_o, output, 32*NUM_MASTERS, and m_ack_o and m_err_o, each output, NUM_MASTERS, per-master responses.
REQ-012 SHALL have ports s_addr_o, output, 32, s_data_o, output, 32, s_sel_o, output, 4, and s_we_o, output, 1, shared slave-side request fields.
REQ-013 SHALL have ports s_cyc_o and s_stb_o, each output, NUM_SLAVES, per-slave strobes.
REQ-014 SHALL have ports s_data_i, input, 32*NUM_SLAVES, and s_ack_i and s_err_i, each input, NUM_SLAVES, per-slave responses.
REQ-015 SHALL have port grant_o, output, NUM_MASTERS, one-hot current owner, all-zero when idle.
REQ-016 SHALL have port busy_o, output, 1, high while any master owns the bus.

Function
REQ-017 SHALL implement a two-state FSM: IDLE and OWNED.
REQ-018 In IDLE, with any m_cyc_i high, SHALL register a grant next cycle to the first requesting master scanning upward (with wrap) from last_grant+1, then enter OWNED.
REQ-019 last_grant SHALL update on each new grant; after reset last_grant = NUM_MASTERS-1, so master 0 wins first.
REQ-020 In OWNED, SHALL hold the grant while the owner's m_cyc_i is high; other masters' requests are ignored (no preemption).
REQ-021 On owner m_cyc_i low, SHALL return to IDLE next cycle; one dead cycle exists between owners.
REQ-022 Slave index = owner m_addr_i[SEL_HI:SEL_LO], decoded combinationally from the owner's current inputs.
REQ-023 In OWNED, s_cyc_o[idx] SHALL follow owner m_cyc_i and s_stb_o[idx] SHALL follow owner m_stb_i; all other bits are 0.
REQ-024 s_addr_o, s_data_o, s_sel_o and s_we_o SHALL be muxed from the owner, and SHALL be 0 in IDLE.
REQ-025 SHALL route s_ack_i[idx], s_err_i[idx] and s_data_i[idx] combinationally to the owner's m_ack_o, m_err_o and m_data_o; non-owners see 0.
REQ-026 Response paths SHALL be gated by owner m_stb_i; a zero-wait slave gives single-cycle ack.
REQ-027 If idx >= NUM_SLAVES (decode miss), SHALL assert no s_stb_o and drive the owner's m_err_o high combinationally while owner m_stb_i is high.
REQ-028 SHALL keep a 16-bit stall counter, cleared when owner m_stb_i is low, on any ack/err, or in IDLE, and incremented otherwise.
REQ-029 When the counter equals TIMEOUT, SHALL assert owner m_err_o for that cycle and force s_stb_o[idx] to 0 for that cycle; the counter then clears.
REQ-030 Simultaneous slave ack and err SHALL forward both unchanged; the master treats err as dominant.
REQ-031 grant_o and busy_o SHALL be registered outputs reflecting the FSM state.

Reset
REQ-032 With rst high at a rising edge, SHALL enter IDLE, clear grant_o, busy_o and the stall counter, and set last_grant = NUM_MASTERS-1.
REQ-033 While in reset, all s_cyc_o, s_stb_o, m_ack_o and m_err_o SHALL be 0.
REQ-034 A reset asserted mid-transfer SHALL abort it with no ack or err generated.
REQ-035 After reset release, the first grant SHALL occur one cycle after a request.

Verification
REQ-036 M0 reads address 0x1000_0004, slave 1 acks the same cycle with 0xDEAD_BEEF -> s_stb_o=4'b0010 one cycle after request; m_data_o[31:0]=0xDEAD_BEEF with m_ack_o[0].
REQ-037 M0 and M1 raise cyc in the same cycle after reset, each doing 2 transfers -> M0 granted first, one dead cycle, then M1; the next simultaneous request goes to M0 again.
REQ-038 M1 accesses 0x5000_0000 with NUM_SLAVES=4 -> no s_stb_o; m_err_o[1] high while stb is high.
REQ-039 TIMEOUT=8, slave never acks -> m_err_o asserted on the 9th stalled cycle with s_stb_o low that cycle.
REQ-040 rst pulsed during an OWNED write -> grant_o=0, busy_o=0 next cycle, no ack issued.
REQ-041 While M0 holds a burst (cyc high across 5 stb cycles), M1 requests -> M1 is not granted until M0 drops cyc.
